// File: rtl/bg_pattern_pkg.sv
// Shared types and constants for the background/test-pattern stage.
package bg_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BORDER  = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BARS    = 2'd3
    } bg_mode_e;

    localparam logic [11:0] BLANK_COLOR = 12'h333;

    // Element 0 is the rightmost entry: white on the left edge of the screen.
    localparam logic [7:0][11:0] BAR_PALETTE = {
        12'h000, 12'h00f, 12'hf00, 12'hf0f,
        12'h0f0, 12'h0ff, 12'hff0, 12'hfff
    };

endpackage

// File: rtl/vga_delay_line.sv
// Generic WIDTH x STAGES register pipe used to keep VGA fields aligned.
module vga_delay_line #(
    parameter int WIDTH  = 38,
    parameter int STAGES = 1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_pipe [STAGES];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[STAGES-1];

endmodule

// File: rtl/bg_pattern_gen.sv
// Background/test-pattern stage with frame-synchronous mode switching.
// Optional feature: define BG_SCROLL_EN to scroll the checker 1 px per frame.
import bg_pattern_pkg::*;

module bg_pattern_gen #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int BORDER_W    = 1,
    parameter int CELL_LOG2   = 5,
    parameter int BAR_LOG2    = 7,
    parameter int PIPE_STAGES = 1
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [1:0]  mode_in,
    input  logic        mode_req,
    output logic        mode_ack,
    input  logic [11:0] fg_color,
    input  logic [11:0] bg_color,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] C_BW   = 11'(BORDER_W);
    localparam logic [10:0] C_H_HI = 11'(H_ACTIVE - BORDER_W);
    localparam logic [10:0] C_V_HI = 11'(V_ACTIVE - BORDER_W);
    localparam int          DL_W   = 38;

    logic        r_vs_prev;
    bg_mode_e    r_mode;
    bg_mode_e    r_pend_mode;
    logic        r_pend_vld;
    logic        r_mode_ack;
    logic [7:0]  r_frame_cnt;

    logic        w_boundary;
    logic        w_take;
    bg_mode_e    w_mode_next;
    logic [10:0] w_hx;
    logic        w_border;
    logic        w_checker;
    logic [10:0] w_bar_full;
    logic [2:0]  w_bar_idx;
    logic [11:0] w_rgb;
    logic [DL_W-1:0] w_pipe_in;
    logic [DL_W-1:0] w_pipe_out;

    assign w_boundary = vsync_in & ~r_vs_prev;

    // w_mode_next also colours the boundary pixel itself, so no frame is torn.
    always_comb begin
        w_take      = 1'b0;
        w_mode_next = r_mode;
        if (w_boundary) begin
            if (mode_req) begin
                w_take      = 1'b1;
                w_mode_next = bg_mode_e'(mode_in);
            end else if (r_pend_vld) begin
                w_take      = 1'b1;
                w_mode_next = r_pend_mode;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev   <= 1'b1;
            r_mode      <= MODE_BORDER;
            r_pend_mode <= MODE_SOLID;
            r_pend_vld  <= 1'b0;
            r_mode_ack  <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_vs_prev  <= vsync_in;
            r_mode     <= w_mode_next;
            r_mode_ack <= w_take;
            if (w_boundary) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_pend_vld  <= 1'b0;
            end else if (mode_req) begin
                r_pend_mode <= bg_mode_e'(mode_in);
                r_pend_vld  <= 1'b1;
            end
        end
    end

`ifdef BG_SCROLL_EN
    assign w_hx = hcount_in + {3'b000, r_frame_cnt};
`else
    assign w_hx = hcount_in;
`endif

    always_comb begin
        w_border   = (vcount_in < C_BW) || (vcount_in >= C_V_HI) ||
                     (hcount_in < C_BW) || (hcount_in >= C_H_HI);
        w_checker  = ((((w_hx >> CELL_LOG2) ^ (vcount_in >> CELL_LOG2)) & 11'd1) != 11'd0);
        w_bar_full = hcount_in >> BAR_LOG2;
        w_bar_idx  = (w_bar_full > 11'd7) ? 3'd7 : w_bar_full[2:0];
        w_rgb      = bg_color;
        if (hblnk_in || vblnk_in) begin
            w_rgb = BLANK_COLOR;
        end else begin
            case (w_mode_next)
                MODE_SOLID:   w_rgb = bg_color;
                MODE_BORDER:  w_rgb = w_border  ? fg_color : bg_color;
                MODE_CHECKER: w_rgb = w_checker ? fg_color : bg_color;
                MODE_BARS:    w_rgb = BAR_PALETTE[w_bar_idx];
            endcase
        end
    end

    assign w_pipe_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, w_rgb};

    vga_delay_line #(
        .WIDTH  (DL_W),
        .STAGES (PIPE_STAGES)
    ) u_delay (
        .pclk  (pclk),
        .rst_n (rst_n),
        .din   (w_pipe_in),
        .dout  (w_pipe_out)
    );

    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} = w_pipe_out;
    assign mode_ack  = r_mode_ack;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_bg_pattern_gen.sv
// Directed bench for bg_pattern_gen with a two-stage output pipe.
module tb_bg_pattern_gen;

    localparam int PS = 2;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [1:0]  mode_in = '0;
    logic        mode_req = 1'b0;
    logic        mode_ack;
    logic [11:0] fg_color = 12'hfff, bg_color = 12'h000;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 pclk = ~pclk;

    bg_pattern_gen #(.PIPE_STAGES(PS)) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .mode_in    (mode_in),
        .mode_req   (mode_req),
        .mode_ack   (mode_ack),
        .fg_color   (fg_color),
        .bg_color   (bg_color),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .frame_cnt  (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic pix(input int h, input int v);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
    endtask

    task automatic chk_pix(input string tag, input int h, input int v, input logic [11:0] exp);
        pix(h, v);
        step(PS);
        chk(tag, 32'(rgb_out), 32'(exp));
    endtask

    task automatic vs_pulse();
        vsync_in = 1'b0;
        step(1);
        vsync_in = 1'b1;
        step(1);
    endtask

    initial begin
        // reset with arbitrary inputs
        pix(5, 7);
        hsync_in = 1'b1;
        step(3);
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        chk("rst_hcnt", 32'(hcount_out), 32'h0);
        chk("rst_hsync", 32'(hsync_out), 32'h0);
        chk("rst_frame", 32'(frame_cnt), 32'h0);
        chk("rst_ack", 32'(mode_ack), 32'h0);

        rst_n    = 1'b1;
        hblnk_in = 1'b1;
        step(PS);
        chk("blank_rgb", 32'(rgb_out), 32'h333);
        chk("fwd_hcnt", 32'(hcount_out), 32'd5);
        chk("fwd_vcnt", 32'(vcount_out), 32'd7);
        chk("fwd_hsync", 32'(hsync_out), 32'h1);
        hblnk_in = 1'b0;
        hsync_in = 1'b0;

        // BORDER is the reset mode
        chk_pix("bord_0_0", 0, 0, 12'hfff);
        chk_pix("bord_1023_5", 1023, 5, 12'hfff);
        chk_pix("bord_5_767", 5, 767, 12'hfff);
        chk_pix("bord_1_1", 1, 1, 12'h000);
        chk_pix("bord_1022_766", 1022, 766, 12'h000);
        vblnk_in = 1'b1;
        chk_pix("bord_vblank", 0, 0, 12'h333);
        vblnk_in = 1'b0;

        // latency: pixel A then B, A appears exactly PS cycles later
        pix(0, 0);
        step(1);
        pix(1, 1);
        step(1);
        chk("lat_a", 32'(rgb_out), 32'hfff);
        step(1);
        chk("lat_b", 32'(rgb_out), 32'h000);

        // mid-frame request for CHECKER is held until vsync rises
        pix(5, 5);
        mode_in  = 2'd2;
        mode_req = 1'b1;
        step(1);
        mode_req = 1'b0;
        mode_in  = 2'd0;
        chk("hs_noack", 32'(mode_ack), 32'h0);
        chk_pix("hs_pre", 0, 0, 12'hfff);
        chk("hs_noack2", 32'(mode_ack), 32'h0);
        pix(40, 5);
        vsync_in = 1'b1;
        step(1);
        chk("hs_ack", 32'(mode_ack), 32'h1);
        chk("hs_frame", 32'(frame_cnt), 32'd1);
        step(PS - 1);
        chk("hs_bnd_pix", 32'(rgb_out), 32'hfff);
        chk("hs_ack_drop", 32'(mode_ack), 32'h0);
        chk_pix("chk_33_0", 33, 0, 12'hfff);
        chk_pix("chk_0_0", 0, 0, 12'h000);
        chk_pix("chk_33_32", 33, 32, 12'h000);
        vsync_in = 1'b0;

        // two requests in one frame: last one (SOLID) wins, single ack
        bg_color = 12'h0a5;
        chk_pix("two_pre", 160, 0, 12'hfff);
        mode_in  = 2'd3;
        mode_req = 1'b1;
        step(1);
        mode_req = 1'b0;
        step(1);
        mode_in  = 2'd0;
        mode_req = 1'b1;
        step(1);
        mode_req = 1'b0;
        mode_in  = 2'd2;
        chk("two_noack", 32'(mode_ack), 32'h0);
        chk_pix("two_still_chk", 160, 0, 12'hfff);
        pix(130, 10);
        vsync_in = 1'b1;
        step(1);
        chk("two_ack", 32'(mode_ack), 32'h1);
        chk("two_frame", 32'(frame_cnt), 32'd2);
        step(PS - 1);
        chk("two_bnd_pix", 32'(rgb_out), 32'h0a5);
        chk_pix("two_solid", 900, 10, 12'h0a5);
        chk("two_one_ack", 32'(mode_ack), 32'h0);

        // request coincident with the vsync rise is applied at once
        vsync_in = 1'b0;
        step(1);
        pix(130, 0);
        vsync_in = 1'b1;
        mode_in  = 2'd3;
        mode_req = 1'b1;
        step(1);
        mode_req = 1'b0;
        mode_in  = 2'd0;
        chk("coin_ack", 32'(mode_ack), 32'h1);
        chk("coin_frame", 32'(frame_cnt), 32'd3);
        step(PS - 1);
        chk("coin_bnd_pix", 32'(rgb_out), 32'hff0);

        // BARS palette and saturation
        chk_pix("bars_0", 0, 0, 12'hfff);
        chk_pix("bars_384", 384, 0, 12'h0f0);
        chk_pix("bars_640", 640, 0, 12'hf00);
        chk_pix("bars_900", 900, 0, 12'h000);
        chk_pix("bars_1023", 1023, 0, 12'h000);
        hblnk_in = 1'b1;
        chk_pix("bars_hblank", 130, 0, 12'h333);
        hblnk_in = 1'b0;

        // boundary without a pending request
        pix(0, 0);
        vs_pulse();
        chk("nopend_ack", 32'(mode_ack), 32'h0);
        chk("nopend_frame", 32'(frame_cnt), 32'd4);
        step(PS - 1);
        chk("nopend_mode", 32'(rgb_out), 32'hfff);
        vsync_in = 1'b0;

        // reset mid-handshake drops the pending request
        mode_in  = 2'd2;
        mode_req = 1'b1;
        step(1);
        mode_req = 1'b0;
        mode_in  = 2'd0;
        pix(40, 5);
        rst_n = 1'b0;
        #1;
        chk("arst_rgb", 32'(rgb_out), 32'h0);
        chk("arst_frame", 32'(frame_cnt), 32'h0);
        step(1);
        rst_n = 1'b1;
        vs_pulse();
        chk("arst_noack", 32'(mode_ack), 32'h0);
        chk("arst_frame1", 32'(frame_cnt), 32'd1);
        step(PS - 1);
        chk("arst_border", 32'(rgb_out), 32'h0a5);
        vsync_in = 1'b0;

        // fresh reset, then CHECKER from frame_cnt 0
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        pix(31, 0);
        mode_in  = 2'd2;
        mode_req = 1'b1;
        vsync_in = 1'b1;
        step(1);
        mode_req = 1'b0;
        chk("scr_ack", 32'(mode_ack), 32'h1);
        chk("scr_frame", 32'(frame_cnt), 32'd1);
        step(PS - 1);
        chk("scr_31_f0", 32'(rgb_out), 32'h0a5);
`ifdef BG_SCROLL_EN
        chk_pix("scr_31_f1", 31, 0, 12'hfff);
`else
        chk_pix("scr_31_f1", 31, 0, 12'h0a5);
`endif
        chk_pix("scr_32_f1", 32, 0, 12'hfff);

        for (int i = 0; i < 254; i++) begin
            vs_pulse();
        end
        chk("wrap_255", 32'(frame_cnt), 32'd255);
        vs_pulse();
        chk("wrap_0", 32'(frame_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bg_pattern_gen.md
# bg_pattern_gen

Parametrised background/test-pattern stage for the VGA pixel pipeline. Sits directly after the timing generator and ahead of the sprite/overlay stages. Forwards hcount/vcount/sync/blank with matched latency and produces a 12-bit RGB background in one of four run-time selectable modes. Mode changes are requested through a req/ack handshake and take effect only at a frame boundary, so a frame is never torn.

## Interface
Parameters:
- H_ACTIVE, 1024: active pixels per line.
- V_ACTIVE, 768: active lines per frame.
- BORDER_W, 1: border thickness in pixels (1..16).
- CELL_LOG2, 5: checker cell size is 2^CELL_LOG2 pixels.
- BAR_LOG2, 7: colour-bar width is 2^BAR_LOG2 pixels.
- PIPE_STAGES, 1: output latency in pclk cycles (1..4).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - pclk  in  1  pixel clock.
  - rst_n  in  1  asynchronous active-low reset.
- Timing inputs from the timing generator:
  - hcount_in, vcount_in  in  11 each  pixel coordinates.
  - hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  sync and blanking.
- Mode-change handshake:
  - mode_in  in  2  requested mode: 0 SOLID, 1 BORDER, 2 CHECKER, 3 BARS.
  - mode_req  in  1  one-cycle request strobe; mode_in is valid in the same cycle.
  - mode_ack  out  1  one-cycle pulse when the new mode takes effect.
- Colour inputs:
  - fg_color, bg_color  in  12 each  foreground and background colours.
- Outputs:
  - hcount_out, vcount_out  out  11 each  delayed copies of the count inputs.
  - hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed copies of the sync and blanking inputs.
  - rgb_out  out  12  pixel colour.
  - frame_cnt  out  8  frame counter.

## Operation
- Blanking: when hblnk_in or vblnk_in is high, the pixel colour is 12'h333 regardless of mode.
- SOLID: every active pixel is bg_color.
- BORDER: a pixel is fg_color if vcount < BORDER_W, or vcount ≥ V_ACTIVE−BORDER_W, or hcount < BORDER_W, or hcount ≥ H_ACTIVE−BORDER_W. Otherwise it is bg_color.
- CHECKER: let hx = hcount (see SCROLL). A pixel is fg_color when bit 0 of ((hx>>CELL_LOG2) ^ (vcount>>CELL_LOG2)) is 1. Otherwise it is bg_color.
- BARS: idx = hcount>>BAR_LOG2, saturated at 7.
  - Palette by idx 0..7: fff, ff0, 0ff, 0f0, f0f, f00, 00f, 000.
  - fg_color and bg_color are ignored in this mode.
- Frame boundary is a rising edge of vsync_in (vsync_in=1 with vs_prev=0). vs_prev is a register.
- Mode handshake:
  - mode_req captures mode_in into a pending register and sets pend_vld.
  - A later mode_req before the frame boundary overwrites the pending value (last request wins).
  - At the frame boundary, if pend_vld is set: active mode ← pending, pend_vld clears, and mode_ack pulses in the same cycle the new mode takes effect.
  - If mode_req coincides with the frame boundary, that cycle's mode_in is applied immediately and acked.
  - A frame boundary with no pending request: mode unchanged, no ack.
- frame_cnt increments by 1 at each frame boundary and wraps 255→0.
- Arithmetic: counts are 11-bit unsigned. Comparisons use constants of at least 11 bits. No signed arithmetic.

## Timing
- All timing and RGB outputs are delayed by exactly PIPE_STAGES cycles relative to the inputs.
- The colour is computed from the stage-0 inputs and the active mode, so every field stays aligned through the pipe.
- mode_ack and frame_cnt are not delayed: they are registered once, in the boundary cycle + 1.
- The mode is used for the pixel in the boundary cycle itself. Its colour therefore appears PIPE_STAGES cycles later.
- Reset values:
  - All pipe outputs, rgb_out and mode_ack are 0.
  - frame_cnt is 0.
  - Active mode is BORDER and pend_vld is 0.
  - vs_prev is 1, so there is no spurious boundary after reset.
- Asserting rst_n low mid-frame or mid-handshake clears everything immediately. A pending request is lost and not acked.

## Configuration
- BG_SCROLL_EN defined: in CHECKER mode, hx = (hcount + frame_cnt) mod 2048, so the pattern shifts 1 px per frame.
- BG_SCROLL_EN undefined: hx = hcount, the checker is static, and no adder is synthesised.
- Other modes are unaffected by BG_SCROLL_EN.

## Structure
- The shared package bg_pattern_pkg holds:
  - the mode typedef (2-bit enum SOLID/BORDER/CHECKER/BARS);
  - the blank colour constant 12'h333;
  - the 8-entry bar palette constant.
- One sub-module, vga_delay_line: a generic width × PIPE_STAGES register pipe with async active-low reset.
  - It carries the packed {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb} bundle.
  - It is reused by downstream overlay stages.

## Test plan
- Reset check: rst_n low, inputs arbitrary → all outputs 0. After release with hblnk_in=1, rgb_out=12'h333 after PIPE_STAGES cycles.
- BORDER, default params, fg=fff, bg=000 → rgb_out=fff at (0,0), (1023,5) and (5,767). rgb_out=000 at (1,1) and (1022,766).
- Mode handshake: mode_req with mode_in=2 mid-frame → no change or ack until the vsync rise. The ack pulses in that cycle, and checker colours appear from that pixel, delayed by PIPE_STAGES.
- Two requests (3 then 0) in one frame → one ack at the boundary, and the resulting mode is SOLID. A request coincident with the vsync rise is applied and acked the same cycle.
- BARS, BAR_LOG2=7: hcount=0 → fff; 130 → ff0; 900 → 000; 1023 → 000 (saturated).
- BG_SCROLL_EN, CHECKER, CELL_LOG2=5: at frame_cnt=0, (31,0) → bg and (32,0) → fg. After 1 frame, (31,0) → fg. After 256 frames, frame_cnt wraps to 0.
